// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with busy scoreboard and post-reset sequential clear.
// Write latency 1 cycle, reads combinational (optional same-cycle bypass); no backpressure, ready flags end of clear.
module regfile_mp #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic [NWR-1:0]    w_ena,
  input  logic [NWR*AW-1:0] w_addr,
  input  logic [NWR*DW-1:0] w_data,
  input  logic [NRD-1:0]    r_ena,
  input  logic [NRD*AW-1:0] r_addr,
  output logic [NRD*DW-1:0] r_data,
  output logic [NRD-1:0]    r_busy,
  input  logic              alloc_ena,
  input  logic [AW-1:0]     alloc_addr
);

  localparam int DEPTH = 2**AW;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_cnt, clr_nxt;
  logic            ready_nxt;
  logic [DEPTH-1:0] busy, busy_nxt;
  logic [DW-1:0]   mem [DEPTH];
  logic            run;
  logic [AW-1:0]   ra;
  logic [DW-1:0]   rd;

  assign run = rst && (state == RUN);

  always_comb begin
    state_nxt = state;
    clr_nxt   = clr_cnt;
    ready_nxt = ready;
    case (state)
      CLEAR: begin
        if (clr_cnt == AW'(DEPTH-1)) begin
          state_nxt = RUN;
          ready_nxt = 1'b1;
        end else begin
          clr_nxt = clr_cnt + AW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ready   <= 1'b0;
      busy    <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_nxt;
      ready   <= ready_nxt;
      if (state == RUN)
        busy <= busy_nxt;
    end
  end

  // Allocation is applied after the write clears so it wins on a same-address collision.
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < NWR; i++) begin
      if (w_ena[i] && w_addr[i*AW +: AW] != '0)
        busy_nxt[w_addr[i*AW +: AW]] = 1'b0;
    end
    if (alloc_ena && alloc_addr != '0)
      busy_nxt[alloc_addr] = 1'b1;
  end

  // No reset on the array so it can map onto RAM; later ports overwrite earlier ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == CLEAR) begin
        mem[clr_cnt] <= '0;
      end else begin
        for (int i = 0; i < NWR; i++) begin
          if (w_ena[i] && w_addr[i*AW +: AW] != '0)
            mem[w_addr[i*AW +: AW]] <= w_data[i*DW +: DW];
        end
      end
    end
  end

  always_comb begin
    r_data = '0;
    r_busy = '0;
    ra     = '0;
    rd     = '0;
    for (int j = 0; j < NRD; j++) begin
      ra = r_addr[j*AW +: AW];
      if (run && r_ena[j] && ra != '0) begin
        rd = mem[ra];
        if (BYPASS != 0) begin
          for (int i = 0; i < NWR; i++) begin
            if (w_ena[i] && w_addr[i*AW +: AW] == ra)
              rd = w_data[i*DW +: DW];
          end
        end
        r_data[j*DW +: DW] = rd;
        r_busy[j]          = busy[ra];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: BYPASS=1 and BYPASS=0 instances share one stimulus stream.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  w_ena = '0;
  logic [9:0]  w_addr = '0;
  logic [63:0] w_data = '0;
  logic [1:0]  r_ena = '0;
  logic [9:0]  r_addr = '0;
  logic        alloc_ena = 1'b0;
  logic [4:0]  alloc_addr = '0;

  logic        ready1, ready0;
  logic [63:0] r_data1, r_data0;
  logic [1:0]  r_busy1, r_busy0;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  regfile_mp #(.DW(32), .AW(5), .NRD(2), .NWR(2), .BYPASS(1)) dut1 (
    .clk(clk), .rst(rst), .ready(ready1),
    .w_ena(w_ena), .w_addr(w_addr), .w_data(w_data),
    .r_ena(r_ena), .r_addr(r_addr), .r_data(r_data1), .r_busy(r_busy1),
    .alloc_ena(alloc_ena), .alloc_addr(alloc_addr)
  );

  regfile_mp #(.DW(32), .AW(5), .NRD(2), .NWR(2), .BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .ready(ready0),
    .w_ena(w_ena), .w_addr(w_addr), .w_data(w_data),
    .r_ena(r_ena), .r_addr(r_addr), .r_data(r_data0), .r_busy(r_busy0),
    .alloc_ena(alloc_ena), .alloc_addr(alloc_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w_ena = '0; w_addr = '0; w_data = '0;
    r_ena = '0; r_addr = '0;
    alloc_ena = 1'b0; alloc_addr = '0;
  endtask

  task automatic test_reset();
    int ready_at;
    bit bad;
    rst = 1'b0;
    idle();
    r_ena = 2'b11; r_addr = {5'd7, 5'd4};
    repeat (3) tick();
    #1;
    chk_cnt++; if (ready1 !== 1'b0 || ready0 !== 1'b0) $display("FAIL reset_ready got %b/%b exp 0/0", ready1, ready0); else pass_cnt++;
    chk_cnt++; if (r_data1 !== 64'h0 || r_data0 !== 64'h0) $display("FAIL reset_rdata got %h/%h exp 0", r_data1, r_data0); else pass_cnt++;
    chk_cnt++; if (r_busy1 !== 2'b00) $display("FAIL reset_rbusy got %b exp 00", r_busy1); else pass_cnt++;
    rst = 1'b1;
    ready_at = 0;
    bad = 1'b0;
    for (int n = 1; n <= 40 && ready_at == 0; n++) begin
      if (n == 10) begin
        w_ena = 2'b01; w_addr = {5'd0, 5'd4}; w_data = {32'h0, 32'hFFFF_FFFF};
      end else begin
        w_ena = '0;
      end
      #1;
      if (r_data1 !== 64'h0 || r_data0 !== 64'h0 || r_busy1 !== 2'b00) bad = 1'b1;
      tick();
      if (ready1 === 1'b1) ready_at = n;
    end
    chk_cnt++; if (ready_at != 32) $display("FAIL clear_ready_edge got %0d exp 32", ready_at); else pass_cnt++;
    chk_cnt++; if (ready0 !== 1'b1) $display("FAIL clear_ready_nobyp got %b exp 1", ready0); else pass_cnt++;
    chk_cnt++; if (bad) $display("FAIL clear_rdata_zero got nonzero exp 0"); else pass_cnt++;
    idle();
    r_ena = 2'b01; r_addr = {5'd0, 5'd4};
    #1;
    chk_cnt++; if (r_data1 !== 64'h0 || r_data0 !== 64'h0) $display("FAIL clear_r4 got %h/%h exp 0", r_data1, r_data0); else pass_cnt++;
  endtask

  task automatic test_write_read();
    idle();
    w_ena = 2'b11; w_addr = {5'd0, 5'd7}; w_data = {32'h1234_5678, 32'hDEAD_BEEF};
    tick();
    idle();
    r_ena = 2'b11; r_addr = {5'd7, 5'd7};
    #1;
    chk_cnt++; if (r_data1 !== {32'hDEAD_BEEF, 32'hDEAD_BEEF}) $display("FAIL wr_r7_byp got %h exp deadbeefdeadbeef", r_data1); else pass_cnt++;
    chk_cnt++; if (r_data0 !== {32'hDEAD_BEEF, 32'hDEAD_BEEF}) $display("FAIL wr_r7_nobyp got %h exp deadbeefdeadbeef", r_data0); else pass_cnt++;
    r_addr = {5'd0, 5'd7};
    #1;
    chk_cnt++; if (r_data1 !== {32'h0, 32'hDEAD_BEEF}) $display("FAIL wr_r0 got %h exp 00000000deadbeef", r_data1); else pass_cnt++;
  endtask

  task automatic test_conflict_bypass();
    idle();
    w_ena = 2'b11; w_addr = {5'd3, 5'd3}; w_data = {32'h22, 32'h11};
    r_ena = 2'b01; r_addr = {5'd0, 5'd3};
    #1;
    chk_cnt++; if (r_data1 !== 64'h22) $display("FAIL conflict_bypass got %h exp 22", r_data1); else pass_cnt++;
    chk_cnt++; if (r_data0 !== 64'h0) $display("FAIL conflict_nobypass got %h exp 0", r_data0); else pass_cnt++;
    tick();
    w_ena = 2'b01; w_addr = {5'd0, 5'd10}; w_data = {32'h0, 32'h55};
    r_ena = 2'b11; r_addr = {5'd10, 5'd3};
    #1;
    chk_cnt++; if (r_data1 !== {32'h55, 32'h22}) $display("FAIL conflict_next_byp got %h exp 0000005500000022", r_data1); else pass_cnt++;
    chk_cnt++; if (r_data0 !== {32'h0, 32'h22}) $display("FAIL conflict_next_nobyp got %h exp 0000000000000022", r_data0); else pass_cnt++;
    tick();
    idle();
  endtask

  task automatic test_scoreboard();
    idle();
    alloc_ena = 1'b1; alloc_addr = 5'd9;
    r_ena = 2'b10; r_addr = {5'd9, 5'd0};
    #1;
    chk_cnt++; if (r_busy1 !== 2'b00) $display("FAIL sb_pre got %b exp 00", r_busy1); else pass_cnt++;
    tick();
    alloc_ena = 1'b0;
    #1;
    chk_cnt++; if (r_busy1 !== 2'b10 || r_busy0 !== 2'b10) $display("FAIL sb_alloc got %b/%b exp 10/10", r_busy1, r_busy0); else pass_cnt++;
    tick();
    w_ena = 2'b01; w_addr = {5'd0, 5'd9}; w_data = {32'h0, 32'h99};
    #1;
    chk_cnt++; if (r_busy1 !== 2'b10 || r_busy0 !== 2'b10) $display("FAIL sb_write_cycle got %b/%b exp 10/10", r_busy1, r_busy0); else pass_cnt++;
    chk_cnt++; if (r_data1 !== {32'h99, 32'h0}) $display("FAIL sb_write_bypass got %h exp 0000009900000000", r_data1); else pass_cnt++;
    tick();
    w_ena = '0;
    #1;
    chk_cnt++; if (r_busy1 !== 2'b00 || r_busy0 !== 2'b00) $display("FAIL sb_cleared got %b/%b exp 00/00", r_busy1, r_busy0); else pass_cnt++;
    chk_cnt++; if (r_data0 !== {32'h99, 32'h0}) $display("FAIL sb_data got %h exp 0000009900000000", r_data0); else pass_cnt++;
    alloc_ena = 1'b1; alloc_addr = 5'd9;
    w_ena = 2'b01; w_addr = {5'd0, 5'd9}; w_data = {32'h0, 32'h100};
    tick();
    idle();
    r_ena = 2'b10; r_addr = {5'd9, 5'd0};
    #1;
    chk_cnt++; if (r_busy1 !== 2'b10) $display("FAIL sb_alloc_wins got %b exp 10", r_busy1); else pass_cnt++;
    chk_cnt++; if (r_data0 !== {32'h100, 32'h0}) $display("FAIL sb_alloc_wr_data got %h exp 0000010000000000", r_data0); else pass_cnt++;
  endtask

  task automatic test_read_enable();
    idle();
    r_addr = {5'd9, 5'd7};
    #1;
    chk_cnt++; if (r_data1 !== 64'h0 || r_data0 !== 64'h0) $display("FAIL ren_data got %h/%h exp 0", r_data1, r_data0); else pass_cnt++;
    chk_cnt++; if (r_busy1 !== 2'b00) $display("FAIL ren_busy got %b exp 00", r_busy1); else pass_cnt++;
    r_ena = 2'b11;
    #1;
    chk_cnt++; if (r_data1 !== {32'h100, 32'hDEAD_BEEF}) $display("FAIL ren_on_data got %h exp 00000100deadbeef", r_data1); else pass_cnt++;
    chk_cnt++; if (r_busy1 !== 2'b10) $display("FAIL ren_on_busy got %b exp 10", r_busy1); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    int ready_at;
    idle();
    w_ena = 2'b01; w_addr = {5'd0, 5'd5}; w_data = {32'h0, 32'hA5A5_A5A5};
    tick();
    idle();
    alloc_ena = 1'b1; alloc_addr = 5'd5;
    tick();
    idle();
    r_ena = 2'b01; r_addr = {5'd0, 5'd5};
    #1;
    chk_cnt++; if (r_data1 !== 64'hA5A5_A5A5 || r_busy1 !== 2'b01) $display("FAIL mid_pre got %h/%b exp a5a5a5a5/01", r_data1, r_busy1); else pass_cnt++;
    rst = 1'b0;
    w_ena = 2'b10; w_addr = {5'd6, 5'd0}; w_data = {32'h66, 32'h0};
    alloc_ena = 1'b1; alloc_addr = 5'd6;
    #1;
    chk_cnt++; if (r_data1 !== 64'h0 || r_busy1 !== 2'b00) $display("FAIL mid_in_reset got %h/%b exp 0/00", r_data1, r_busy1); else pass_cnt++;
    tick();
    rst = 1'b1;
    w_ena = '0; alloc_ena = 1'b0;
    #1;
    chk_cnt++; if (ready1 !== 1'b0 || ready0 !== 1'b0) $display("FAIL mid_ready_drop got %b/%b exp 0/0", ready1, ready0); else pass_cnt++;
    ready_at = 0;
    for (int n = 1; n <= 40 && ready_at == 0; n++) begin
      tick();
      if (ready1 === 1'b1) ready_at = n;
    end
    chk_cnt++; if (ready_at != 32) $display("FAIL mid_ready_edge got %0d exp 32", ready_at); else pass_cnt++;
    r_ena = 2'b11; r_addr = {5'd9, 5'd5};
    #1;
    chk_cnt++; if (r_data1 !== 64'h0 || r_data0 !== 64'h0) $display("FAIL mid_r5_r9 got %h/%h exp 0", r_data1, r_data0); else pass_cnt++;
    chk_cnt++; if (r_busy1 !== 2'b00) $display("FAIL mid_busy got %b exp 00", r_busy1); else pass_cnt++;
    r_addr = {5'd6, 5'd6};
    #1;
    chk_cnt++; if (r_data1 !== 64'h0 || r_busy1 !== 2'b00) $display("FAIL mid_r6 got %h/%b exp 0/00", r_data1, r_busy1); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_conflict_bypass();
    test_scoreboard();
    test_read_enable();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
